// File: rtl/drygascon_bdo_out.sv
// DryGASCON output side: serializes 128-bit result blocks onto the bdo stream
// and, on decryption, checks the computed tag against the expected tag.
module drygascon_bdo_out #(
    parameter int CCW      = 32,
    parameter int CCWdiv8  = 4,
    parameter int SIZE_BLK = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE_BLK-1:0] blk_data,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic [3:0]          blk_type,
    input  logic [4:0]          blk_bytes,
    input  logic                blk_is_tag,
    input  logic                decrypt,
    input  logic [SIZE_BLK-1:0] exp_tag,
    input  logic                exp_tag_valid,
    output logic                exp_tag_ready,
    output logic [CCW-1:0]      bdo,
    output logic                bdo_valid,
    input  logic                bdo_ready,
    output logic [3:0]          bdo_type,
    output logic [CCWdiv8-1:0]  bdo_valid_bytes,
    output logic                end_of_block,
    output logic                msg_auth_valid,
    input  logic                msg_auth_ready,
    output logic                msg_auth
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OUT,
        S_CMP,
        S_AUTH
    } state_t;

    state_t              state;
    logic [SIZE_BLK-1:0] data;
    logic [4:0]          rem;

    // Byte-valid mask for a word given the bytes still left in the block.
    function automatic logic [3:0] thermo(input logic [4:0] b);
        logic [3:0] m;
        m = 4'b0000;
        if (b >= 5'd4)
            m = 4'b1111;
        else if (b == 5'd3)
            m = 4'b1110;
        else if (b == 5'd2)
            m = 4'b1100;
        else if (b == 5'd1)
            m = 4'b1000;
        return m;
    endfunction

    function automatic logic [31:0] mask_word(input logic [31:0] w,
                                              input logic [4:0]  b);
        logic [3:0]  m;
        logic [31:0] r;
        m = thermo(b);
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = m[3-i] ? w[31-8*i -: 8] : 8'h00;
        return r;
    endfunction

    function automatic logic [4:0] rem_after(input logic [4:0] b);
        return (b > 5'd4) ? b - 5'd4 : 5'd0;
    endfunction

    // No path from bdo_ready: acceptance depends only on registered state.
    assign blk_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            data            <= '0;
            rem             <= '0;
            bdo             <= '0;
            bdo_valid       <= 1'b0;
            bdo_type        <= '0;
            bdo_valid_bytes <= '0;
            end_of_block    <= 1'b0;
            exp_tag_ready   <= 1'b0;
            msg_auth_valid  <= 1'b0;
            msg_auth        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (blk_valid) begin
                        if (blk_is_tag && decrypt) begin
                            data          <= blk_data;
                            exp_tag_ready <= 1'b1;
                            state         <= S_CMP;
                        end else if (blk_bytes != 5'd0) begin
                            bdo             <= mask_word(blk_data[127:96],
                                                         blk_bytes);
                            bdo_valid_bytes <= thermo(blk_bytes);
                            end_of_block    <= (blk_bytes <= 5'd4);
                            bdo_type        <= blk_type;
                            bdo_valid       <= 1'b1;
                            data            <= blk_data << 32;
                            rem             <= rem_after(blk_bytes);
                            state           <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (bdo_ready) begin
                        if (end_of_block) begin
                            bdo             <= '0;
                            bdo_valid       <= 1'b0;
                            bdo_valid_bytes <= '0;
                            bdo_type        <= '0;
                            end_of_block    <= 1'b0;
                            state           <= S_IDLE;
                        end else begin
                            bdo             <= mask_word(data[127:96], rem);
                            bdo_valid_bytes <= thermo(rem);
                            end_of_block    <= (rem <= 5'd4);
                            data            <= data << 32;
                            rem             <= rem_after(rem);
                        end
                    end
                end
                S_CMP: begin
                    if (exp_tag_valid) begin
                        exp_tag_ready  <= 1'b0;
                        msg_auth_valid <= 1'b1;
                        msg_auth       <= (data == exp_tag);
                        state          <= S_AUTH;
                    end
                end
                S_AUTH: begin
                    if (msg_auth_ready) begin
                        msg_auth_valid <= 1'b0;
                        msg_auth       <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drygascon_bdo_out.sv
// Directed bench for drygascon_bdo_out: serialization, backpressure,
// empty block, tag verification and asynchronous reset.
module tb_drygascon_bdo_out;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [3:0]   blk_type;
    logic [4:0]   blk_bytes;
    logic         blk_is_tag;
    logic         decrypt;
    logic [127:0] exp_tag;
    logic         exp_tag_valid;
    logic         exp_tag_ready;
    logic [31:0]  bdo;
    logic         bdo_valid;
    logic         bdo_ready;
    logic [3:0]   bdo_type;
    logic [3:0]   bdo_valid_bytes;
    logic         end_of_block;
    logic         msg_auth_valid;
    logic         msg_auth_ready;
    logic         msg_auth;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] D = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    drygascon_bdo_out dut (
        .clk             (clk),
        .rst             (rst),
        .blk_data        (blk_data),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_type        (blk_type),
        .blk_bytes       (blk_bytes),
        .blk_is_tag      (blk_is_tag),
        .decrypt         (decrypt),
        .exp_tag         (exp_tag),
        .exp_tag_valid   (exp_tag_valid),
        .exp_tag_ready   (exp_tag_ready),
        .bdo             (bdo),
        .bdo_valid       (bdo_valid),
        .bdo_ready       (bdo_ready),
        .bdo_type        (bdo_type),
        .bdo_valid_bytes (bdo_valid_bytes),
        .end_of_block    (end_of_block),
        .msg_auth_valid  (msg_auth_valid),
        .msg_auth_ready  (msg_auth_ready),
        .msg_auth        (msg_auth)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] w,
                        input logic [3:0] vb, input logic eob,
                        input logic [3:0] ty);
        chk({tag, ".valid"}, bdo_valid, 1'b1);
        chk({tag, ".bdo"}, bdo, w);
        chk({tag, ".vb"}, bdo_valid_bytes, vb);
        chk({tag, ".eob"}, end_of_block, eob);
        chk({tag, ".type"}, bdo_type, ty);
        chk({tag, ".blk_ready"}, blk_ready, 1'b0);
    endtask

    task automatic offer(input logic [127:0] d, input logic [4:0] n,
                         input logic [3:0] ty, input logic tg,
                         input logic dec);
        blk_data   = d;
        blk_bytes  = n;
        blk_type   = ty;
        blk_is_tag = tg;
        decrypt    = dec;
        blk_valid  = 1'b1;
        chk("offer.blk_ready", blk_ready, 1'b1);
        step();
        blk_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        blk_data = '0;
        blk_valid = 1'b0;
        blk_type = '0;
        blk_bytes = '0;
        blk_is_tag = 1'b0;
        decrypt = 1'b0;
        exp_tag = '0;
        exp_tag_valid = 1'b0;
        bdo_ready = 1'b0;
        msg_auth_ready = 1'b0;

        // reset state
        step();
        chk("rst.blk_ready", blk_ready, 1'b0);
        chk("rst.bdo_valid", bdo_valid, 1'b0);
        chk("rst.bdo", bdo, 32'h0);
        chk("rst.eob", end_of_block, 1'b0);
        chk("rst.auth_valid", msg_auth_valid, 1'b0);
        chk("rst.exp_ready", exp_tag_ready, 1'b0);
        rst = 1'b0;
        step();
        chk("idle.blk_ready", blk_ready, 1'b1);

        // full block
        bdo_ready = 1'b1;
        offer(D, 5'd16, 4'b0100, 1'b0, 1'b0);
        beat("full1", 32'h00112233, 4'hF, 1'b0, 4'b0100);
        step();
        beat("full2", 32'h44556677, 4'hF, 1'b0, 4'b0100);
        step();
        beat("full3", 32'h8899AABB, 4'hF, 1'b0, 4'b0100);
        step();
        beat("full4", 32'hCCDDEEFF, 4'hF, 1'b1, 4'b0100);
        step();
        chk("full.done_valid", bdo_valid, 1'b0);
        chk("full.done_ready", blk_ready, 1'b1);

        // partial block with backpressure
        bdo_ready = 1'b0;
        offer(D, 5'd6, 4'b0101, 1'b0, 1'b0);
        beat("part1", 32'h00112233, 4'hF, 1'b0, 4'b0101);
        step();
        beat("part1hold", 32'h00112233, 4'hF, 1'b0, 4'b0101);
        bdo_ready = 1'b1;
        step();
        beat("part2", 32'h44550000, 4'hC, 1'b1, 4'b0101);
        bdo_ready = 1'b0;
        step();
        beat("part2hold", 32'h44550000, 4'hC, 1'b1, 4'b0101);
        bdo_ready = 1'b1;
        step();
        chk("part.done_valid", bdo_valid, 1'b0);
        chk("part.done_ready", blk_ready, 1'b1);

        // empty block
        offer(D, 5'd0, 4'b0100, 1'b0, 1'b0);
        chk("empty.valid", bdo_valid, 1'b0);
        chk("empty.ready", blk_ready, 1'b1);
        step();
        chk("empty.valid2", bdo_valid, 1'b0);

        // decrypt tag, match
        exp_tag = D;
        offer(D, 5'd16, 4'b0010, 1'b1, 1'b1);
        chk("tagm.exp_ready", exp_tag_ready, 1'b1);
        chk("tagm.bdo_valid", bdo_valid, 1'b0);
        chk("tagm.blk_ready", blk_ready, 1'b0);
        exp_tag_valid = 1'b1;
        step();
        exp_tag_valid = 1'b0;
        chk("tagm.exp_ready0", exp_tag_ready, 1'b0);
        chk("tagm.auth_valid", msg_auth_valid, 1'b1);
        chk("tagm.auth", msg_auth, 1'b1);
        step();
        chk("tagm.auth_hold", msg_auth_valid, 1'b1);
        chk("tagm.bdo_valid2", bdo_valid, 1'b0);
        msg_auth_ready = 1'b1;
        step();
        msg_auth_ready = 1'b0;
        chk("tagm.auth_done", msg_auth_valid, 1'b0);
        chk("tagm.blk_ready2", blk_ready, 1'b1);

        // decrypt tag, mismatch in bit 0
        exp_tag = D ^ 128'h1;
        offer(D, 5'd16, 4'b0010, 1'b1, 1'b1);
        chk("tagx.exp_ready", exp_tag_ready, 1'b1);
        exp_tag_valid = 1'b1;
        step();
        exp_tag_valid = 1'b0;
        chk("tagx.auth_valid", msg_auth_valid, 1'b1);
        chk("tagx.auth", msg_auth, 1'b0);
        msg_auth_ready = 1'b1;
        step();
        msg_auth_ready = 1'b0;
        chk("tagx.auth_done", msg_auth_valid, 1'b0);
        chk("tagx.bdo_valid", bdo_valid, 1'b0);

        // encrypt tag
        offer(D, 5'd16, 4'b0010, 1'b1, 1'b0);
        beat("enc1", 32'h00112233, 4'hF, 1'b0, 4'b0010);
        step();
        beat("enc2", 32'h44556677, 4'hF, 1'b0, 4'b0010);
        step();
        beat("enc3", 32'h8899AABB, 4'hF, 1'b0, 4'b0010);
        chk("enc.auth_valid", msg_auth_valid, 1'b0);
        step();
        beat("enc4", 32'hCCDDEEFF, 4'hF, 1'b1, 4'b0010);
        step();
        chk("enc.done_valid", bdo_valid, 1'b0);
        chk("enc.auth_valid2", msg_auth_valid, 1'b0);

        // asynchronous reset during beat 2
        offer(D, 5'd16, 4'b0100, 1'b0, 1'b0);
        step();
        beat("rstm2", 32'h44556677, 4'hF, 1'b0, 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("rstm.bdo_valid", bdo_valid, 1'b0);
        chk("rstm.blk_ready", blk_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("rstm.idle_ready", blk_ready, 1'b1);
        chk("rstm.valid0", bdo_valid, 1'b0);
        step();
        chk("rstm.valid1", bdo_valid, 1'b0);
        step();
        chk("rstm.valid2", bdo_valid, 1'b0);
        chk("rstm.auth", msg_auth_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
